// File: rtl/dac_mcp4921_pkg.sv
// Shared constants for the MCP4921 DAC driver: FSM state encodings,
// command-word configuration bits and the command-word builder.
package dac_mcp4921_pkg;

  // FSM state encodings (fixed values keep the encoding stable for legacy tools)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_LDAC  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // MCP4921 command nibble: DAC A, unbuffered VREF, gain 1x, output active
  localparam logic CFG_CHANNEL = 1'b0;
  localparam logic CFG_BUFFER  = 1'b0;
  localparam logic CFG_GAIN    = 1'b1;
  localparam logic CFG_SHDN    = 1'b1;

  // Assemble the 16-bit SPI word sent MSB first
  function automatic logic [15:0] build_word(input logic [11:0] code);
    return {CFG_CHANNEL, CFG_BUFFER, CFG_GAIN, CFG_SHDN, code};
  endfunction

endpackage

// File: rtl/dac_mcp4921_clk_div_tick.sv
// Divider producing a one-cycle tick every CLK_DIV cycles. A restart puts the
// count back to zero so the first tick lands CLK_DIV cycles after the restart.
module clk_div_tick #(
  parameter int CLK_DIV = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       tick_r;

  // Next count: restart wins, otherwise wrap at LAST
  always_comb begin
    cnt_nxt_s = 8'd0;
    if (restart) begin
      cnt_nxt_s = 8'd0;
    end else if (cnt_r == LAST) begin
      cnt_nxt_s = 8'd0;
    end else begin
      cnt_nxt_s = cnt_r + 8'd1;
    end
  end

  // Count register and registered tick (high while the count sits at LAST)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= 8'd0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/dac_mcp4921.sv
// MCP4921 12-bit SPI DAC driver. One latch request sends one 16-bit frame
// (SPI mode 0,0), then pulses LDAC to update the analog output. Requests that
// arrive while a frame is in flight are kept in a one-deep, newest-wins slot.
module dac_mcp4921
  import dac_mcp4921_pkg::*;
#(
  parameter int CLK_DIV  = 30,
  parameter int LDAC_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch,
  input  logic [11:0] value,
  output logic        cs_dac,
  output logic        clk_dac,
  output logic        sdo_dac,
  output logic        ldac_dac,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LDAC_LAST = 8'(LDAC_LEN - 1);

  logic [2:0]  state_r;
  logic        cs_r;
  logic        sclk_r;
  logic        sdo_r;
  logic        ldac_r;
  logic        busy_r;
  logic        done_r;
  logic [14:0] shift_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  ldac_cnt_r;
  logic        pend_valid_r;
  logic [11:0] pend_val_r;

  logic        start_s;
  logic [11:0] start_val_s;
  logic [15:0] start_word_s;
  logic        tick_s;

  // Frame start: fresh request in IDLE, or any queued/coincident request at DONE.
  // A latch in the DONE cycle is newer than the pending slot, so it wins.
  always_comb begin
    start_s      = 1'b0;
    start_val_s  = 12'd0;
    if (state_r == ST_IDLE) begin
      start_s = latch;
    end else if (state_r == ST_DONE) begin
      start_s = latch | pend_valid_r;
    end else begin
      start_s = 1'b0;
    end
    if (latch) begin
      start_val_s = value;
    end else begin
      start_val_s = pend_val_r;
    end
    start_word_s = build_word(start_val_s);
  end

  clk_div_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (start_s),
    .tick    (tick_s)
  );

  // One-deep pending request slot, newest wins, cleared when a frame starts
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_r <= 1'b0;
      pend_val_r   <= 12'd0;
    end else if (start_s) begin
      pend_valid_r <= 1'b0;
    end else if (latch && (state_r != ST_IDLE)) begin
      pend_valid_r <= 1'b1;
      pend_val_r   <= value;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Frame sequencer: SETUP -> 16 bits of SHIFT -> HOLD -> GAP -> LDAC -> DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cs_r       <= 1'b1;
      sclk_r     <= 1'b0;
      sdo_r      <= 1'b0;
      ldac_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      shift_r    <= 15'd0;
      bit_cnt_r  <= 4'd0;
      ldac_cnt_r <= 8'd0;
    end else if (start_s) begin
      state_r    <= ST_SETUP;
      cs_r       <= 1'b0;
      sclk_r     <= 1'b0;
      sdo_r      <= start_word_s[15];
      shift_r    <= start_word_s[14:0];
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      ldac_r     <= 1'b1;
      bit_cnt_r  <= 4'd0;
      ldac_cnt_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        ST_SETUP: begin
          if (tick_s) begin
            state_r <= ST_SHIFT;
            sclk_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            if (sclk_r) begin
              // Falling edge: present the next bit, the DAC samples on the rise
              sclk_r <= 1'b0;
              if (bit_cnt_r != 4'd15) begin
                sdo_r   <= shift_r[14];
                shift_r <= {shift_r[13:0], 1'b0};
              end
            end else if (bit_cnt_r == 4'd15) begin
              state_r <= ST_HOLD;
            end else begin
              sclk_r    <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (tick_s) begin
            state_r <= ST_GAP;
            cs_r    <= 1'b1;
            sdo_r   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            state_r    <= ST_LDAC;
            ldac_r     <= 1'b0;
            ldac_cnt_r <= 8'd0;
          end
        end
        ST_LDAC: begin
          if (ldac_cnt_r == LDAC_LAST) begin
            state_r <= ST_DONE;
            ldac_r  <= 1'b1;
            done_r  <= 1'b1;
          end else begin
            ldac_cnt_r <= ldac_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cs_r    <= 1'b1;
          sclk_r  <= 1'b0;
          sdo_r   <= 1'b0;
          ldac_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cs_dac   = cs_r;
  assign clk_dac  = sclk_r;
  assign sdo_dac  = sdo_r;
  assign ldac_dac = ldac_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_dac_mcp4921.sv
// Scoreboard bench for dac_mcp4921: expected SPI words are queued when a
// request is driven and compared when the DUT closes a frame (cs_dac rises).
module tb_dac_mcp4921;

  localparam int H  = 30;
  localparam int LL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        latch = 1'b0;
  logic [11:0] value = 12'd0;
  logic        cs_dac, clk_dac, sdo_dac, ldac_dac, busy, done;

  always #10 clk = ~clk;

  dac_mcp4921 #(.CLK_DIV(H), .LDAC_LEN(LL)) dut (
    .clk      (clk),
    .reset    (reset),
    .latch    (latch),
    .value    (value),
    .cs_dac   (cs_dac),
    .clk_dac  (clk_dac),
    .sdo_dac  (sdo_dac),
    .ldac_dac (ldac_dac),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] sb_q[$];

  // Monitor state
  int          cyc = 0;
  int          cs_low_cnt = 0;
  int          nbits = 0;
  int          last_rise = 0;
  int          cs_high_cyc = 0;
  int          ldac_start = 0;
  int          done_cnt = 0;
  int          ldac_pulses = 0;
  logic [15:0] rx_word = 16'd0;
  logic        cs_p = 1'b1, clk_p = 1'b0, sdo_p = 1'b0, ldac_p = 1'b1, done_p = 1'b0;

  // Protocol monitor sampling on the falling system-clock edge
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      cs_low_cnt = 0;
      nbits      = 0;
    end else begin
      chk("sclk_while_cs_high", {31'd0, cs_dac & clk_dac}, 32'd0);
      if (!cs_dac) cs_low_cnt++;
      if (clk_dac && !clk_p) begin
        rx_word = {rx_word[14:0], sdo_dac};
        if (nbits > 0) chk("sclk_period", cyc - last_rise, 2 * H);
        last_rise = cyc;
        nbits++;
      end
      if (clk_dac && clk_p) chk("sdo_stable_high", {31'd0, sdo_dac}, {31'd0, sdo_p});
      if (cs_dac && !cs_p) begin
        chk("cs_low_len", cs_low_cnt, 34 * H);
        chk("bit_count", nbits, 16);
        chk("sb_has_entry", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) chk("frame_word", {16'd0, rx_word}, {16'd0, sb_q.pop_front()});
        chk("sdo_idle", {31'd0, sdo_dac}, 32'd0);
        cs_high_cyc = cyc;
        cs_low_cnt  = 0;
        nbits       = 0;
      end
      if (!ldac_dac && ldac_p) begin
        chk("ldac_gap", cyc - cs_high_cyc, H);
        ldac_start = cyc;
      end
      if (ldac_dac && !ldac_p) begin
        chk("ldac_len", cyc - ldac_start, LL);
        ldac_pulses++;
      end
      if (done) begin
        chk("done_width", {31'd0, done_p}, 32'd0);
        chk("done_ldac_high", {31'd0, ldac_dac}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        done_cnt++;
      end
    end
    cs_p   = cs_dac;
    clk_p  = clk_dac;
    sdo_p  = sdo_dac;
    ldac_p = ldac_dac;
    done_p = done;
  end

  function automatic logic [15:0] exp_word(input logic [11:0] v);
    logic [3:0] hdr;
    hdr = 4'b0011;
    return {hdr, v};
  endfunction

  task automatic send(input logic [11:0] v);
    @(posedge clk); #1;
    latch = 1'b1;
    value = v;
    sb_q.push_back(exp_word(v));
    @(posedge clk); #1;
    latch = 1'b0;
  endtask

  task automatic pulse_latch(input logic [11:0] v);
    @(posedge clk); #1;
    latch = 1'b1;
    value = v;
    @(posedge clk); #1;
    latch = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  initial begin
    int idle_bad;
    int d0, l0, base, n;

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", {31'd0, cs_dac}, 32'd1);
    chk("rst_sclk", {31'd0, clk_dac}, 32'd0);
    chk("rst_sdo", {31'd0, sdo_dac}, 32'd0);
    chk("rst_ldac", {31'd0, ldac_dac}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle with no requests
    idle_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ({cs_dac, clk_dac, sdo_dac, ldac_dac, busy, done} !== 6'b100100) idle_bad++;
    end
    chk("idle_2000", idle_bad, 0);

    // Single frame 0x801
    send(12'h801);
    @(negedge clk);
    chk("start_cs", {31'd0, cs_dac}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_sdo_msb", {31'd0, sdo_dac}, 32'd0);
    wait_done(1, 1500);
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_done_busy", {31'd0, busy}, 32'd0);

    // Full-scale and zero codes
    send(12'hFFF);
    wait_done(2, 1500);
    send(12'h000);
    wait_done(3, 1500);

    // Two requests during a frame: only the newest is sent afterwards
    send(12'h0AB);
    repeat (100) @(posedge clk);
    pulse_latch(12'h123);
    repeat (10) @(posedge clk);
    @(posedge clk); #1;
    latch = 1'b1;
    value = 12'h456;
    sb_q.push_back(exp_word(12'h456));
    @(posedge clk); #1;
    latch = 1'b0;
    wait_done(5, 3000);
    repeat (1200) @(negedge clk);
    chk("no_extra_frame", done_cnt, 5);
    chk("sb_empty_pending", sb_q.size(), 0);

    // Reset in mid-frame aborts without LDAC or done; latch under reset ignored
    send(12'h555);
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b1;
    latch = 1'b1;
    value = 12'h777;
    d0 = done_cnt;
    l0 = ldac_pulses;
    @(posedge clk); #1;
    latch = 1'b0;
    @(negedge clk);
    chk("abort_cs", {31'd0, cs_dac}, 32'd1);
    chk("abort_sclk", {31'd0, clk_dac}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    repeat (1500) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_ldac", ldac_pulses, l0);
    chk("abort_cs_idle", {31'd0, cs_dac}, 32'd1);
    send(12'h9A5);
    wait_done(d0 + 1, 1500);

    // Latch coincident with done starts the next frame right after done
    @(negedge clk);
    base = done_cnt;
    send(12'h111);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 2000);
    chk("coinc_done_seen", {31'd0, done}, 32'd1);
    latch = 1'b1;
    value = 12'hC3C;
    sb_q.push_back(exp_word(12'hC3C));
    @(posedge clk); #1;
    latch = 1'b0;
    @(negedge clk);
    chk("coinc_cs", {31'd0, cs_dac}, 32'd0);
    chk("coinc_busy", {31'd0, busy}, 32'd1);
    wait_done(base + 2, 3000);

    repeat (20) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
